// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder
//    Unsigned adder built from an explicit chain of 1-bit full-adder cells.
//    The carry ripples from bit 0 up to bit width-1. Sum and carry-out are
//    registered, so the latency is one cycle and a new operation is accepted
//    every cycle.
//
//    Optional build macro: RIPPLE_CARRY_ADDER_OVF_EN
//       When defined, a registered signed-overflow flag (ovf) is added as an
//       output port. When undefined, the port does not exist and sum/cout
//       behave exactly the same.
//
//    Parameter width: operand and sum width, legal range 1..64.

// Single full-adder cell: one bit of the ripple chain.
module rca_full_adder_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   logic p_s;   // propagate term

   assign p_s = a_i ^ b_i;
   assign s_o = p_s ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & p_s);

endmodule

module ripple_carry_adder #(
   parameter int unsigned width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   input  logic             cin,
   output logic [width-1:0] sum,
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   // Signed overflow occurs when the carry into the MSB differs from the
   // carry out of it.
   function automatic logic signed_overflow(input logic c_msb_out,
                                            input logic c_msb_in);
      signed_overflow = c_msb_out ^ c_msb_in;
   endfunction

   // carry_s[i] is the carry into cell i; carry_s[width] is the final carry.
   logic [width:0]   carry_s;
   logic [width-1:0] sum_s;

   assign carry_s[0] = cin;

   // One full-adder cell per bit; carry moves strictly from cell i to i+1.
   for (genvar i = 0; i < width; i++) begin : gen_cell
      rca_full_adder_cell u_cell (
         .a_i (a[i]),
         .b_i (b[i]),
         .c_i (carry_s[i]),
         .s_o (sum_s[i]),
         .c_o (carry_s[i+1])
      );
   end

   logic [width-1:0] sum_d,  sum_q;
   logic             cout_d, cout_q;

   // Next-state values for the output register: straight from the chain.
   always_comb begin
      sum_d  = sum_s;
      cout_d = carry_s[width];
   end

   // Output register; asynchronous reset clears it immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q  <= {width{1'b0}};
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
   logic ovf_d, ovf_q;

   // Overflow flag next state; for width 1 this compares carry_s[1] and cin.
   always_comb begin
      ovf_d = signed_overflow(carry_s[width], carry_s[width-1]);
   end

   // Overflow register shares latency and reset behaviour with sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder (width 8): directed cases,
// exhaustive cin=0 sweep, and randomized traffic against an arithmetic model.
module tb_ripple_carry_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [W-1:0] sum;
   logic         cout;
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
   logic         ovf;
`endif

   int checks;
   int failures;

   ripple_carry_adder #(.width(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
      .ovf  (ovf),
`endif
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation.
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: plain integer addition, result is {cout, sum}.
   function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci);
      int unsigned t;
      t = int'(x) + int'(y) + int'(ci);
      return t[W:0];
   endfunction

   // Reference: two's-complement overflow from the operand and result signs.
   function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic ci);
      int sx, sy, r;
      sx = (x >= 8'd128) ? int'(x) - 256 : int'(x);
      sy = (y >= 8'd128) ? int'(y) - 256 : int'(y);
      r  = sx + sy + int'(ci);
      return (r > 127) || (r < -128);
   endfunction

   // Check all outputs against a given expectation.
   task automatic check_outputs(input string tag, input logic [W:0] exp_res, input logic exp_ovf);
      check(tag, {cout, sum}, exp_res);
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
      check({tag, "_ovf"}, ovf, exp_ovf);
`endif
   endtask

   // Drive one operation, let one edge capture it, and check the result.
   task automatic apply(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci);
      a = x; b = y; cin = ci;
      @(posedge clk); #1;
      check_outputs(tag, model_add(x, y, ci), model_ovf(x, y, ci));
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Reset held with nonzero inputs while the clock runs.
      rst = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b1;
      #1;
      check_outputs("reset_initial", 9'h000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_outputs("reset_hold", 9'h000, 1'b0);
      end

      // Release reset between edges, then a basic add.
      rst = 1'b0;
      a = 8'h12; b = 8'h34; cin = 1'b0;
      #2;
      check_outputs("basic_before_edge", 9'h000, 1'b0);
      @(posedge clk); #1;
      check_outputs("basic_add", 9'h046, 1'b0);

      // Full-length carry ripple and wrap-around.
      apply("ripple_ff_00_c1", 8'hFF, 8'h00, 1'b1);
      check("ripple_ff_00_c1_lit", {cout, sum}, 9'h100);
      apply("wrap_ff_ff_c1", 8'hFF, 8'hFF, 1'b1);
      check("wrap_ff_ff_c1_lit", {cout, sum}, 9'h1FF);
      apply("all_zero", 8'h00, 8'h00, 1'b0);
      check("all_zero_lit", {cout, sum}, 9'h000);

      // Back-to-back operations, one result per cycle.
      apply("b2b_01_01", 8'h01, 8'h01, 1'b0);
      check("b2b_01_01_lit", {cout, sum}, 9'h002);
      apply("b2b_80_80", 8'h80, 8'h80, 1'b0);
      check("b2b_80_80_lit", {cout, sum}, 9'h100);
      apply("b2b_7f_01", 8'h7F, 8'h01, 1'b0);
      check("b2b_7f_01_lit", {cout, sum}, 9'h080);
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
      check("ovf_7f_01_lit", ovf, 1'b1);
      apply("ovf_80_80", 8'h80, 8'h80, 1'b0);
      check("ovf_80_80_lit", ovf, 1'b1);
      apply("ovf_ff_01", 8'hFF, 8'h01, 1'b0);
      check("ovf_ff_01_lit", ovf, 1'b0);
`endif

      // Mid-stream reset: outputs clear without a clock edge.
      apply("pre_midreset", 8'hFF, 8'hFF, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_outputs("midreset_immediate", 9'h000, 1'b0);
      @(posedge clk); #1;
      check_outputs("midreset_hold", 9'h000, 1'b0);
      rst = 1'b0;

      // Exhaustive sweep, cin = 0: a increments each cycle, b on a wrap.
      for (int bi = 0; bi < 256; bi++) begin
         for (int ai = 0; ai < 256; ai++) begin
            apply("sweep", 8'(ai), 8'(bi), 1'b0);
         end
      end

      // Randomized traffic including cin.
      for (int i = 0; i < 2000; i++) begin
         apply("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
